// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the time-setting controller and its surroundings:
// prescaler tick and raw keys in, counter-chain strobes and display blanking out.
interface clock_set_ctrl_if;
  logic       sec_tick;
  logic       key_mode_n;
  logic       key_inc_n;
  logic       sec_en;
  logic       sec_clr;
  logic       min_inc;
  logic       hr_inc;
  logic [1:0] mode;
  logic       blank_min;
  logic       blank_hr;

  modport slave (
    input  sec_tick, key_mode_n, key_inc_n,
    output sec_en, sec_clr, min_inc, hr_inc, mode, blank_min, blank_hr
  );

  modport master (
    output sec_tick, key_mode_n, key_inc_n,
    input  sec_en, sec_clr, min_inc, hr_inc, mode, blank_min, blank_hr
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces mode/inc keys, runs the RUN/SET_MIN/SET_HR
// FSM and drives the seconds enable, increment strobes and digit blanking.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_SECS    = 10,
  parameter int CNT_W           = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_HR  = 2'b10
  } state_t;

  localparam int TMO_W = (TIMEOUT_SECS > 1) ? $clog2(TIMEOUT_SECS) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_SECS - 1);

  // Key bit 0 = mode, bit 1 = inc; all key levels are active-low.
  logic [1:0]            key_raw_s;
  logic [1:0]            sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            press_s;
  logic                  mode_evt_s, inc_evt_s;

  state_t                state_q, state_d;
  logic                  blink_q, blink_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  sec_en_q, sec_en_d;
  logic                  sec_clr_q, sec_clr_d;
  logic                  min_inc_q, min_inc_d;
  logic                  hr_inc_q, hr_inc_d;
  logic                  blank_min_q, blank_min_d;
  logic                  blank_hr_q, blank_hr_d;

  assign key_raw_s  = {bus.key_inc_n, bus.key_mode_n};
  assign press_s    = deb_prev_q & ~deb_q;
  assign mode_evt_s = press_s[0];
  assign inc_evt_s  = press_s[1];

  // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DEB_LAST) begin
        deb_d[k] = sync2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= key_raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // Mode FSM; a mode event outranks an inc event arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    blink_d   = blink_q;
    tmo_d     = tmo_q;
    sec_en_d  = 1'b0;
    sec_clr_d = 1'b0;
    min_inc_d = 1'b0;
    hr_inc_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        sec_en_d = bus.sec_tick;
        blink_d  = 1'b1;
        tmo_d    = '0;
        if (mode_evt_s) begin
          state_d   = ST_SET_MIN;
          sec_clr_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_MIN, ST_SET_HR: begin
        if (mode_evt_s) begin
          state_d = (state_q == ST_SET_MIN) ? ST_SET_HR : ST_RUN;
          blink_d = 1'b1;
          tmo_d   = '0;
        end else if (inc_evt_s) begin
          min_inc_d = (state_q == ST_SET_MIN);
          hr_inc_d  = (state_q == ST_SET_HR);
          tmo_d     = '0;
          blink_d   = bus.sec_tick ? ~blink_q : blink_q;
        end else if (bus.sec_tick) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ST_RUN;
            blink_d = 1'b1;
            tmo_d   = '0;
          end else begin
            blink_d = ~blink_q;
            tmo_d   = tmo_q + TMO_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        blink_d = 1'b1;
        tmo_d   = '0;
      end
    endcase
    blank_min_d = (state_d == ST_SET_MIN) & ~blink_d;
    blank_hr_d  = (state_d == ST_SET_HR) & ~blink_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      blink_q     <= 1'b1;
      tmo_q       <= '0;
      sec_en_q    <= 1'b0;
      sec_clr_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hr_inc_q    <= 1'b0;
      blank_min_q <= 1'b0;
      blank_hr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_q     <= blink_d;
      tmo_q       <= tmo_d;
      sec_en_q    <= sec_en_d;
      sec_clr_q   <= sec_clr_d;
      min_inc_q   <= min_inc_d;
      hr_inc_q    <= hr_inc_d;
      blank_min_q <= blank_min_d;
      blank_hr_q  <= blank_hr_d;
    end
  end

  assign bus.mode      = state_q;
  assign bus.sec_en    = sec_en_q;
  assign bus.sec_clr   = sec_clr_q;
  assign bus.min_inc   = min_inc_q;
  assign bus.hr_inc    = hr_inc_q;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_hr  = blank_hr_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (DEBOUNCE_CYCLES=4, TIMEOUT_SECS=3).
module tb_clock_set_ctrl;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   n_sec_en, n_sec_clr, n_min, n_hr;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_SECS   (3),
    .CNT_W          (3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe counters sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.sec_en === 1'b1)  n_sec_en++;
    if (bus.sec_clr === 1'b1) n_sec_clr++;
    if (bus.min_inc === 1'b1) n_min++;
    if (bus.hr_inc === 1'b1)  n_hr++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_pulse();
    bus.sec_tick = 1'b1;
    step(1);
    bus.sec_tick = 1'b0;
  endtask

  task automatic press(input bit m, input bit i);
    if (m) bus.key_mode_n = 1'b0;
    if (i) bus.key_inc_n = 1'b0;
    step(10);
    bus.key_mode_n = 1'b1;
    bus.key_inc_n  = 1'b1;
    step(10);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    checks++;
    if ({bus.sec_en, bus.sec_clr, bus.min_inc, bus.hr_inc, bus.mode, bus.blank_min, bus.blank_hr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {bus.sec_en, bus.sec_clr, bus.min_inc, bus.hr_inc, bus.mode, bus.blank_min, bus.blank_hr});
    end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_run();
    int b_en = n_sec_en;
    int b_min = n_min;
    int b_hr = n_hr;
    for (int t = 0; t < 5; t++) begin
      step(19);
      tick_pulse();
      checks++;
      if (bus.sec_en !== 1'b1) begin errors++; $display("FAIL run_sec_en_hi tick %0d got %b want 1", t, bus.sec_en); end
      step(1);
      checks++;
      if (bus.sec_en !== 1'b0) begin errors++; $display("FAIL run_sec_en_lo tick %0d got %b want 0", t, bus.sec_en); end
    end
    checks++;
    if (n_sec_en - b_en != 5) begin errors++; $display("FAIL run_sec_en_count got %0d want 5", n_sec_en - b_en); end
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL run_mode got %b want 00", bus.mode); end
    checks++;
    if ((n_min - b_min) + (n_hr - b_hr) != 0) begin
      errors++; $display("FAIL run_no_inc got %0d want 0", (n_min - b_min) + (n_hr - b_hr));
    end
  endtask

  task automatic test_mode_press();
    int b_clr = n_sec_clr;
    press(1'b1, 1'b0);
    checks++;
    if (bus.mode !== 2'b01) begin errors++; $display("FAIL mode_first got %b want 01", bus.mode); end
    checks++;
    if (n_sec_clr - b_clr != 1) begin errors++; $display("FAIL mode_sec_clr got %0d want 1", n_sec_clr - b_clr); end
    // Bounce shorter than the debounce window, then settle low.
    bus.key_mode_n = 1'b0; step(2);
    bus.key_mode_n = 1'b1; step(2);
    bus.key_mode_n = 1'b0; step(2);
    bus.key_mode_n = 1'b1; step(2);
    bus.key_mode_n = 1'b0; step(10);
    bus.key_mode_n = 1'b1; step(10);
    checks++;
    if (bus.mode !== 2'b10) begin errors++; $display("FAIL mode_bounce got %b want 10", bus.mode); end
    press(1'b1, 1'b0);
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL mode_wrap got %b want 00", bus.mode); end
    checks++;
    if (n_sec_clr - b_clr != 1) begin errors++; $display("FAIL mode_sec_clr_once got %0d want 1", n_sec_clr - b_clr); end
  endtask

  task automatic test_set_min();
    int b_en, b_min, b_hr;
    press(1'b1, 1'b0);
    b_en = n_sec_en; b_min = n_min; b_hr = n_hr;
    checks++;
    if (bus.blank_min !== 1'b0) begin errors++; $display("FAIL min_blank_entry got %b want 0", bus.blank_min); end
    repeat (3) press(1'b0, 1'b1);
    checks++;
    if (n_min - b_min != 3) begin errors++; $display("FAIL min_inc_count got %0d want 3", n_min - b_min); end
    checks++;
    if (n_hr - b_hr != 0) begin errors++; $display("FAIL min_hr_inc got %0d want 0", n_hr - b_hr); end
    tick_pulse();
    checks++;
    if (bus.blank_min !== 1'b1) begin errors++; $display("FAIL min_blank_t1 got %b want 1", bus.blank_min); end
    tick_pulse();
    checks++;
    if (bus.blank_min !== 1'b0) begin errors++; $display("FAIL min_blank_t2 got %b want 0", bus.blank_min); end
    tick_pulse();
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL min_timeout got %b want 00", bus.mode); end
    checks++;
    if (n_sec_en - b_en != 0) begin errors++; $display("FAIL min_sec_en got %0d want 0", n_sec_en - b_en); end
  endtask

  task automatic test_set_hr();
    int b_clr = n_sec_clr;
    int b_min, b_hr;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    b_min = n_min; b_hr = n_hr;
    checks++;
    if (bus.mode !== 2'b10) begin errors++; $display("FAIL hr_mode got %b want 10", bus.mode); end
    checks++;
    if (bus.blank_hr !== 1'b0) begin errors++; $display("FAIL hr_blank_entry got %b want 0", bus.blank_hr); end
    repeat (2) press(1'b0, 1'b1);
    checks++;
    if (n_hr - b_hr != 2) begin errors++; $display("FAIL hr_inc_count got %0d want 2", n_hr - b_hr); end
    checks++;
    if (n_min - b_min != 0) begin errors++; $display("FAIL hr_min_inc got %0d want 0", n_min - b_min); end
    tick_pulse();
    checks++;
    if ({bus.blank_hr, bus.blank_min} !== 2'b10) begin
      errors++; $display("FAIL hr_blank_t1 got %b want 10", {bus.blank_hr, bus.blank_min});
    end
    tick_pulse();
    checks++;
    if (bus.blank_hr !== 1'b0) begin errors++; $display("FAIL hr_blank_t2 got %b want 0", bus.blank_hr); end
    press(1'b1, 1'b0);
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL hr_exit got %b want 00", bus.mode); end
    checks++;
    if (n_sec_clr - b_clr != 1) begin errors++; $display("FAIL hr_sec_clr got %0d want 1", n_sec_clr - b_clr); end
    tick_pulse();
    checks++;
    if (bus.sec_en !== 1'b1) begin errors++; $display("FAIL hr_sec_en_resume got %b want 1", bus.sec_en); end
  endtask

  task automatic test_timeout();
    int b_min;
    press(1'b1, 1'b0);
    tick_pulse();
    tick_pulse();
    checks++;
    if (bus.mode !== 2'b01) begin errors++; $display("FAIL tmo_t2 got %b want 01", bus.mode); end
    tick_pulse();
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL tmo_t3 got %b want 00", bus.mode); end
    press(1'b1, 1'b0);
    b_min = n_min;
    tick_pulse();
    tick_pulse();
    press(1'b0, 1'b1);
    tick_pulse();
    tick_pulse();
    checks++;
    if (bus.mode !== 2'b01) begin errors++; $display("FAIL tmo_restart got %b want 01", bus.mode); end
    tick_pulse();
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL tmo_after_inc got %b want 00", bus.mode); end
    checks++;
    if (n_min - b_min != 1) begin errors++; $display("FAIL tmo_min_inc got %0d want 1", n_min - b_min); end
  endtask

  task automatic test_collision_reset();
    int b_min, b_hr;
    press(1'b1, 1'b0);
    b_min = n_min; b_hr = n_hr;
    press(1'b1, 1'b1);
    checks++;
    if (bus.mode !== 2'b10) begin errors++; $display("FAIL coll_mode got %b want 10", bus.mode); end
    checks++;
    if ((n_min - b_min) + (n_hr - b_hr) != 0) begin
      errors++; $display("FAIL coll_no_strobe got %0d want 0", (n_min - b_min) + (n_hr - b_hr));
    end
    bus.key_inc_n = 1'b0;
    step(4);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.sec_en, bus.sec_clr, bus.min_inc, bus.hr_inc, bus.mode, bus.blank_min, bus.blank_hr} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %b want 00000000",
               {bus.sec_en, bus.sec_clr, bus.min_inc, bus.hr_inc, bus.mode, bus.blank_min, bus.blank_hr});
    end
    step(3);
    reset_n = 1'b1;
    step(15);
    bus.key_inc_n = 1'b1;
    step(10);
    checks++;
    if (bus.mode !== 2'b00) begin errors++; $display("FAIL post_reset_mode got %b want 00", bus.mode); end
    checks++;
    if ((n_min - b_min) + (n_hr - b_hr) != 0) begin
      errors++; $display("FAIL post_reset_strobe got %0d want 0", (n_min - b_min) + (n_hr - b_hr));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    n_sec_en = 0; n_sec_clr = 0; n_min = 0; n_hr = 0;
    reset_n = 1'b0;
    bus.sec_tick   = 1'b0;
    bus.key_mode_n = 1'b1;
    bus.key_inc_n  = 1'b1;
    test_reset();
    test_run();
    test_mode_press();
    test_set_min();
    test_set_hr();
    test_timeout();
    test_collision_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the digital clock datapath: seconds, minutes and hours counters with their BCD/7-segment display chain. It debounces the two push keys, runs a RUN/SET_MIN/SET_HR mode FSM, and gates the seconds-counter enable. It emits single-cycle increment strobes to the minute and hour counters and blanking controls for the HEX digit pairs. It sits between the 1 Hz prescaler and the counter chain.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable clock cycles required to accept a key level change (5 ms at 50 MHz)
TIMEOUT_SECS, 10, sec_tick count with no inc press in a set mode before auto-return to RUN
CNT_W, 18, width of debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
sec_tick  input  1  one-cycle 1 Hz strobe from prescaler
key_mode_n  input  1  raw mode key, active-low (pressed = 0)
key_inc_n  input  1  raw increment key, active-low
sec_en  output  1  seconds counter count enable
sec_clr  output  1  one-cycle synchronous clear to seconds counter
min_inc  output  1  one-cycle increment strobe to minute counter
hr_inc  output  1  one-cycle increment strobe to hour counter
mode  output  2  00 RUN, 01 SET_MIN, 10 SET_HR (11 unused)
blank_min  output  1  1 = blank minute digits (HEX5/HEX4)
blank_hr  output  1  1 = blank hour digits

Behaviour:
- Reset (reset_n=0, asynchronous): state RUN; mode=00; sec_en=0; sec_clr=min_inc=hr_inc=0; blank_min=blank_hr=0; blink=1; sync flops and debounced levels=1 (released); debounce and timeout counters=0.
- Key conditioning, per key:
  - Two-flop synchronizer.
  - Debounce counter resets to 0 whenever the synced level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - Press event = one-cycle pulse in the cycle after the debounced level goes 1->0. Release generates no event.
  - Holding a key produces exactly one event; there is no auto-repeat.
- Mode FSM, advanced by a mode press event:
  - RUN->SET_MIN->SET_HR->RUN.
  - Registered output mode updates the cycle after the event.
- Entering SET_MIN from RUN: sec_clr=1 for exactly one cycle, concurrent with the mode update.
- RUN: sec_en = registered sec_tick (1-cycle latency). Inc press events are ignored. min_inc=hr_inc=0 (the counter chain carries on its own).
- SET_MIN / SET_HR:
  - sec_en=0.
  - An inc press event gives a one-cycle strobe on min_inc (SET_MIN) or hr_inc (SET_HR) the following cycle. Wrap-around is the counters' responsibility.
- Simultaneous mode and inc events in the same cycle: mode wins, inc is dropped, no strobe.
- Blink:
  - Set to 1 on every entry into a set mode.
  - Toggles on each sec_tick while in a set mode.
  - Forced to 1 in RUN.
  - blank_min = (mode==SET_MIN) & ~blink; blank_hr = (mode==SET_HR) & ~blink. Both registered.
- Timeout:
  - Counter clears on set-mode entry and on each inc event.
  - Increments on each sec_tick in a set mode.
  - When sec_tick arrives with counter == TIMEOUT_SECS-1, the FSM returns to RUN next cycle.
  - sec_tick on the same cycle as an inc event: the inc clear wins.
- Leaving SET_HR to RUN, by key or timeout: no sec_clr. sec_en resumes at the next sec_tick.
- Reset asserted mid-strobe or mid-debounce: all state returns to reset values immediately. No strobe is emitted after reset release until a fresh debounced press.
- mode=11 is unreachable. If reached, the FSM goes to RUN next cycle with all strobes 0.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_SECS=3; sec_tick every 20 cycles.)
1. Reset, then 5 sec_ticks in RUN -> 5 sec_en pulses, each 1 cycle after its tick; mode=00; min_inc=hr_inc=0.
2. key_mode_n low for 10 cycles -> exactly one sec_clr pulse; mode=01. Bouncing 0/1/0 every 2 cycles before settling -> still one event only.
3. In SET_MIN, three clean inc presses -> exactly 3 min_inc strobes, 0 hr_inc, sec_en stays 0. blank_min toggles on each sec_tick, starting at 0 after entry.
4. Mode press twice from RUN, then 2 inc presses -> mode=10, 2 hr_inc strobes, blank_hr toggling. A third mode press -> mode=00, no sec_clr.
5. Enter SET_MIN, no inc presses -> mode returns to 00 one cycle after the 3rd sec_tick. Repeat with an inc press after tick 2 -> return occurs only after 3 further ticks.
6. Mode and inc debounced events in the same cycle while in SET_MIN -> mode=10, no min_inc/hr_inc. Assert reset_n=0 during a held inc key -> all outputs at reset values; no strobe after release of reset.
